// File: rtl/ibex_csr_bank.sv
// rtl/ibex_csr_bank.sv - CSR bank with write/set/clear ops, two-phase commit, sticky locks and stage timeout.
// Optional inverted shadow copies are enabled by defining IBEX_CSR_BANK_SHADOW_EN.
module ibex_csr_bank #(
  parameter int unsigned Width = 32,
  parameter int unsigned NumRegs = 4,
  parameter logic [NumRegs-1:0][Width-1:0] ResetValue = '0,
  parameter bit TwoPhase = 1'b1,
  parameter int unsigned StageTimeout = 16,
  localparam int unsigned AddrW = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_en_i,
  input  logic [AddrW-1:0]   wr_addr_i,
  input  logic [1:0]         wr_op_i,
  input  logic [Width-1:0]   wr_data_i,
  input  logic [NumRegs-1:0] lock_set_i,
  input  logic [AddrW-1:0]   rd_addr_i,
  output logic [Width-1:0]   rd_data_o,
  output logic               rd_error_o,
  output logic [NumRegs-1:0] locked_o,
  output logic               stage_valid_o,
  output logic               commit_o,
  output logic               update_err_o,
  output logic               timeout_o
);

  typedef enum logic {IDLE, STAGED} state_e;

  logic [NumRegs-1:0][Width-1:0] regs_q;
  logic [NumRegs-1:0]            locked_q;
  state_e                        state_q;
  logic [AddrW-1:0]              stage_addr_q;
  logic [Width-1:0]              stage_data_q;
  logic [31:0]                   timer_q;
  logic                          commit_q, err_q, timeout_q;

  logic             addr_ok, rd_ok, reject, accept, store_err, do_commit, same_addr;
  logic [Width-1:0] cur_val, nxt_val;

  assign addr_ok   = (wr_addr_i <= AddrW'(NumRegs - 1));
  assign rd_ok     = (rd_addr_i <= AddrW'(NumRegs - 1));
  assign cur_val   = addr_ok ? regs_q[wr_addr_i] : '0;
  assign same_addr = (wr_addr_i == stage_addr_q);

  always_comb begin
    nxt_val = cur_val;
    case (wr_op_i)
      2'b00:   nxt_val = wr_data_i;
      2'b01:   nxt_val = cur_val | wr_data_i;
      2'b10:   nxt_val = cur_val & ~wr_data_i;
      default: nxt_val = cur_val;
    endcase
  end

  // A lock request in the same cycle as a write to that register wins over the write.
  assign reject = wr_en_i && (!addr_ok || (wr_op_i == 2'b11) ||
                              (addr_ok && (locked_q[wr_addr_i] || lock_set_i[wr_addr_i])));
  assign accept = wr_en_i && !reject;

`ifdef IBEX_CSR_BANK_SHADOW_EN
  logic [NumRegs-1:0][Width-1:0] shadow_q;

  assign store_err  = addr_ok && (regs_q[wr_addr_i] != ~shadow_q[wr_addr_i]);
  assign rd_error_o = rd_ok && (regs_q[rd_addr_i] != ~shadow_q[rd_addr_i]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= ~ResetValue;
    end else if (do_commit) begin
      shadow_q[wr_addr_i] <= ~nxt_val;
    end
  end
`else
  assign store_err  = 1'b0;
  assign rd_error_o = 1'b0;
`endif

  assign do_commit = TwoPhase ? ((state_q == STAGED) && accept && same_addr &&
                                 (nxt_val == stage_data_q) && !store_err)
                              : accept;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q <= ResetValue;
    end else if (do_commit) begin
      regs_q[wr_addr_i] <= nxt_val;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      locked_q     <= '0;
      state_q      <= IDLE;
      stage_addr_q <= '0;
      stage_data_q <= '0;
      timer_q      <= '0;
      commit_q     <= 1'b0;
      err_q        <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      locked_q  <= locked_q | lock_set_i;
      commit_q  <= do_commit;
      err_q     <= reject;
      timeout_q <= 1'b0;
      if (TwoPhase) begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              state_q      <= STAGED;
              stage_addr_q <= wr_addr_i;
              stage_data_q <= nxt_val;
              timer_q      <= '0;
            end
          end
          STAGED: begin
            if (accept && same_addr) begin
              state_q <= IDLE;
              if (!do_commit) err_q <= 1'b1;
            end else if (accept) begin
              // A write elsewhere is flagged but replaces the stage.
              err_q        <= 1'b1;
              stage_addr_q <= wr_addr_i;
              stage_data_q <= nxt_val;
              timer_q      <= '0;
            end else if (lock_set_i[stage_addr_q]) begin
              state_q <= IDLE;
            end else if (!wr_en_i) begin
              if ((StageTimeout != 0) && (timer_q == StageTimeout - 1)) begin
                state_q   <= IDLE;
                timeout_q <= 1'b1;
              end else begin
                timer_q <= timer_q + 32'd1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rd_data_o     = rd_ok ? regs_q[rd_addr_i] : '0;
  assign locked_o      = locked_q;
  assign stage_valid_o = (state_q == STAGED);
  assign commit_o      = commit_q;
  assign update_err_o  = err_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_ibex_csr_bank.sv
// tb/tb_ibex_csr_bank.sv - directed self-checking bench for ibex_csr_bank.
module tb_ibex_csr_bank;

  localparam logic [3:0][31:0] RV = {32'hDEAD_0003, 32'h0000_0002, 32'h0000_0001, 32'h1234_0000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [1:0]  wr_op = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  lock_set = '0;
  logic [1:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_error;
  logic [3:0]  locked;
  logic        stage_valid, commit, update_err, timeout;

  int tests_run = 0;
  int tests_failed = 0;

  ibex_csr_bank #(
    .Width(32), .NumRegs(4), .ResetValue(RV), .TwoPhase(1'b1), .StageTimeout(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_op_i(wr_op),
    .wr_data_i(wr_data), .lock_set_i(lock_set), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .rd_error_o(rd_error), .locked_o(locked), .stage_valid_o(stage_valid),
    .commit_o(commit), .update_err_o(update_err), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [1:0] op, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_op = op; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd_at(input logic [1:0] a);
    rd_addr = a;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_at(2'(i));
      tests_run++;
      if (rd_data !== RV[i]) begin
        tests_failed++; $display("FAIL reset_rd%0d: got %h expected %h", i, rd_data, RV[i]);
      end
    end
    tests_run++;
    if (locked !== 4'b0000) begin tests_failed++; $display("FAIL reset_locked: got %b expected 0000", locked); end
    tests_run++;
    if (stage_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_stage: got %b expected 0", stage_valid); end
    tests_run++;
    if ({commit, update_err, timeout, rd_error} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_pulses: got %b expected 0000", {commit, update_err, timeout, rd_error});
    end
    step();
    tests_run++;
    if ({commit, update_err, timeout} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_pulses_after: got %b expected 000", {commit, update_err, timeout});
    end
  endtask

  task automatic test_double_write();
    wr(2'd1, 2'b00, 32'hA5);
    rd_at(2'd1);
    tests_run++;
    if ({stage_valid, commit} !== 2'b10) begin
      tests_failed++; $display("FAIL dw_phase1: got stage/commit %b expected 10", {stage_valid, commit});
    end
    tests_run++;
    if (rd_data !== 32'h1) begin tests_failed++; $display("FAIL dw_phase1_rd: got %h expected 00000001", rd_data); end
    wr(2'd1, 2'b00, 32'hA5);
    tests_run++;
    if ({stage_valid, commit, update_err} !== 3'b010) begin
      tests_failed++; $display("FAIL dw_phase2: got stage/commit/err %b expected 010", {stage_valid, commit, update_err});
    end
    tests_run++;
    if (rd_data !== 32'hA5) begin tests_failed++; $display("FAIL dw_phase2_rd: got %h expected 000000a5", rd_data); end
    step();
    tests_run++;
    if (commit !== 1'b0) begin tests_failed++; $display("FAIL dw_pulse_width: got %b expected 0", commit); end
  endtask

  task automatic test_mismatch();
    wr(2'd1, 2'b00, 32'hA5);
    wr(2'd1, 2'b00, 32'h5A);
    rd_at(2'd1);
    tests_run++;
    if ({stage_valid, commit, update_err} !== 3'b001) begin
      tests_failed++; $display("FAIL mm_flags: got stage/commit/err %b expected 001", {stage_valid, commit, update_err});
    end
    tests_run++;
    if (rd_data !== 32'hA5) begin tests_failed++; $display("FAIL mm_rd: got %h expected 000000a5", rd_data); end
  endtask

  task automatic test_set_clear();
    wr(2'd2, 2'b00, 32'hF0); wr(2'd2, 2'b00, 32'hF0);
    wr(2'd2, 2'b01, 32'h0F); wr(2'd2, 2'b01, 32'h0F);
    rd_at(2'd2);
    tests_run++;
    if (rd_data !== 32'hFF || commit !== 1'b1) begin
      tests_failed++; $display("FAIL set_op: got %h commit %b expected 000000ff commit 1", rd_data, commit);
    end
    wr(2'd2, 2'b10, 32'h3C); wr(2'd2, 2'b10, 32'h3C);
    tests_run++;
    if (rd_data !== 32'hC3) begin tests_failed++; $display("FAIL clear_op: got %h expected 000000c3", rd_data); end
    wr(2'd2, 2'b11, 32'hFFFF_FFFF);
    tests_run++;
    if ({stage_valid, commit, update_err} !== 3'b001 || rd_data !== 32'hC3) begin
      tests_failed++;
      $display("FAIL reserved_op: got flags %b rd %h expected 001 000000c3", {stage_valid, commit, update_err}, rd_data);
    end
  endtask

  task automatic test_timeout();
    wr(2'd0, 2'b00, 32'h77);
    for (int i = 0; i < 15; i++) step();
    tests_run++;
    if ({stage_valid, timeout} !== 2'b10) begin
      tests_failed++; $display("FAIL to_before: got stage/timeout %b expected 10", {stage_valid, timeout});
    end
    step();
    tests_run++;
    if ({stage_valid, timeout} !== 2'b01) begin
      tests_failed++; $display("FAIL to_expire: got stage/timeout %b expected 01", {stage_valid, timeout});
    end
    wr(2'd0, 2'b00, 32'h88);
    rd_at(2'd0);
    tests_run++;
    if ({stage_valid, commit, timeout} !== 3'b100 || rd_data !== 32'h1234_0000) begin
      tests_failed++;
      $display("FAIL to_restage: got flags %b rd %h expected 100 12340000", {stage_valid, commit, timeout}, rd_data);
    end
    wr(2'd0, 2'b00, 32'h88);
    tests_run++;
    if (commit !== 1'b1 || rd_data !== 32'h88) begin
      tests_failed++; $display("FAIL to_commit: got commit %b rd %h expected 1 00000088", commit, rd_data);
    end
  endtask

  task automatic test_other_addr();
    wr(2'd1, 2'b00, 32'h11);
    wr(2'd2, 2'b00, 32'h22);
    tests_run++;
    if ({stage_valid, commit, update_err} !== 3'b101) begin
      tests_failed++; $display("FAIL oa_switch: got stage/commit/err %b expected 101", {stage_valid, commit, update_err});
    end
    wr(2'd2, 2'b00, 32'h22);
    rd_at(2'd2);
    tests_run++;
    if (commit !== 1'b1 || rd_data !== 32'h22) begin
      tests_failed++; $display("FAIL oa_commit: got commit %b rd %h expected 1 00000022", commit, rd_data);
    end
    rd_at(2'd1);
    tests_run++;
    if (rd_data !== 32'hA5) begin tests_failed++; $display("FAIL oa_r1: got %h expected 000000a5", rd_data); end
  endtask

  task automatic test_lock();
    lock_set = 4'b1000;
    wr(2'd3, 2'b00, 32'hFF);
    lock_set = 4'b0000;
    rd_at(2'd3);
    tests_run++;
    if ({locked, update_err, stage_valid} !== 6'b100010) begin
      tests_failed++; $display("FAIL lock_same_cycle: got lock/err/stage %b expected 100010", {locked, update_err, stage_valid});
    end
    tests_run++;
    if (rd_data !== RV[3]) begin tests_failed++; $display("FAIL lock_r3: got %h expected %h", rd_data, RV[3]); end
    wr(2'd3, 2'b00, 32'hFF);
    tests_run++;
    if ({update_err, stage_valid} !== 2'b10 || rd_data !== RV[3]) begin
      tests_failed++; $display("FAIL lock_sticky: got err/stage %b rd %h expected 10 %h", {update_err, stage_valid}, rd_data, RV[3]);
    end
    wr(2'd0, 2'b00, 32'h99);
    lock_set = 4'b0001;
    step();
    lock_set = 4'b0000;
    tests_run++;
    if ({locked, stage_valid, update_err} !== 6'b100100) begin
      tests_failed++; $display("FAIL lock_staged: got lock/stage/err %b expected 100100", {locked, stage_valid, update_err});
    end
  endtask

`ifdef IBEX_CSR_BANK_SHADOW_EN
  task automatic test_shadow();
    logic [3:0][31:0] sh;
    sh = dut.shadow_q;
    sh[0][0] = ~sh[0][0];
    force dut.shadow_q = sh;
    rd_at(2'd0);
    tests_run++;
    if (rd_error !== 1'b1) begin tests_failed++; $display("FAIL shadow_r0: got %b expected 1", rd_error); end
    rd_at(2'd1);
    tests_run++;
    if (rd_error !== 1'b0) begin tests_failed++; $display("FAIL shadow_r1: got %b expected 0", rd_error); end
    release dut.shadow_q;
  endtask
`endif

  initial begin
    test_reset();
    test_double_write();
    test_mismatch();
    test_set_clear();
    test_timeout();
    test_other_addr();
    test_lock();
`ifdef IBEX_CSR_BANK_SHADOW_EN
    test_shadow();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
